pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_target.sv | 28 ++
 rtl/pc_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Redirect target encodings, FSM states and the default reset PC.
package pc_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] SEL_BR = 2'd0;
    localparam logic [1:0] SEL_J  = 2'd1;
    localparam logic [1:0] SEL_JR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_target.sv
// Combinational control-transfer target calculation.
// Branch, jump, register and reserved (zero) targets.
module pc_target_calc
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] pc4,
    input  logic [25:0] imm26,
    input  logic [31:0] rtarget,
    output logic [31:0] target
);

    logic [31:0] br_off;

    assign br_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};

    // Pick the target for the requested transfer type
    always_comb begin
        target = 32'h0;
        unique case (sel)
            SEL_BR:  target = pc4 + br_off;
            SEL_J:   target = {pc4[31:28], imm26, 2'b00};
            SEL_JR:  target = rtarget;
            default: target = 32'h0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request,
// a registered IF/ID slot, a one-word skid and redirect squashing.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_sel,
    input  logic [31:0] redir_pc4,
    input  logic [25:0] redir_imm26,
    input  logic [31:0] redir_reg,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         drop_q;
    logic         drop_d;
    logic [31:0]  skid_q;
    logic [31:0]  skid_d;

    logic         vld_d;
    logic [31:0]  instr_d;
    logic [31:0]  ipc_d;
    logic [31:0]  ipc4_d;

    logic [31:0]  target;
    logic [31:0]  pc_inc;
    logic         slot_free;

    pc_target_calc u_target (
        .sel     (redir_sel),
        .pc4     (redir_pc4),
        .imm26   (redir_imm26),
        .rtarget (redir_reg),
        .target  (target)
    );

    assign pc_inc    = pc_q + 32'd4;
    assign slot_free = !if_valid || !stall;

    // Next state, next slot contents and the imem request
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        skid_d    = skid_q;
        vld_d     = if_valid && stall;
        instr_d   = if_instr;
        ipc_d     = if_pc;
        ipc4_d    = if_pc4;
        imem_req  = 1'b0;
        imem_addr = 32'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (redir_valid || slot_free) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                state_d   = ST_WAIT;
                drop_d    = redir_valid;
            end
            ST_WAIT: begin
                if (redir_valid) begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = slot_free ? ST_FETCH : ST_IDLE;
                    end else if (slot_free) begin
                        vld_d   = 1'b1;
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        ipc4_d  = pc_inc;
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    vld_d   = 1'b1;
                    instr_d = skid_q;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_inc;
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redir_valid) begin
            pc_d   = target;
            vld_d  = 1'b0;
            skid_d = 32'h0;
        end
    end

    // State, PC, drop flag, skid word and IF/ID slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            skid_q   <= 32'h0;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
            if_pc4   <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            skid_q   <= skid_d;
            if_valid <= vld_d;
            if_instr <= instr_d;
            if_pc    <= ipc_d;
            if_pc4   <= ipc4_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then
// random stall/redirect/latency against a PC-stream reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] redir_pc4;
    logic [25:0] redir_imm26;
    logic [31:0] redir_reg;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int          checks;
    int          failures;
    logic        pending;
    logic [31:0] pend_addr;
    int          cnt;
    int          lat;
    bit          rand_lat;
    bit          spur;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic [31:0] reqq[$];
    logic [31:0] popq[$];
    int          ncons;
    int          nredir;

    pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_sel   (redir_sel),
        .redir_pc4   (redir_pc4),
        .redir_imm26 (redir_imm26),
        .redir_reg   (redir_reg),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] sel,
                                               input logic [31:0] p4,
                                               input logic [25:0] im,
                                               input logic [31:0] rg);
        logic signed [15:0] o;
        int                 off;
        logic [31:0]        t;
        o = im[15:0];
        off = o;
        case (sel)
            2'd0:    t = p4 + 32'(off * 4);
            2'd1:    t = (p4 & 32'hF000_0000) + ({6'd0, im} * 32'd4);
            2'd2:    t = rg;
            default: t = 32'd0;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic st, input logic rv, input logic [1:0] sel,
                        input logic [31:0] p4, input logic [25:0] im,
                        input logic [31:0] rg);
        logic [31:0] tgt;
        logic        hold_chk;
        logic [31:0] s_i;
        logic [31:0] s_p;
        logic [31:0] s_p4;
        stall       = st;
        redir_valid = rv;
        redir_sel   = sel;
        redir_pc4   = p4;
        redir_imm26 = im;
        redir_reg   = rg;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pending && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(pend_addr);
            pending     = 1'b0;
        end else if (pending) begin
            cnt--;
        end else if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        if (imem_req) begin
            chk("one_outstanding", {31'b0, pending}, 32'd0);
            chk("req_addr", imem_addr, exp_req);
            reqq.push_back(imem_addr);
            if (rand_lat) lat = $urandom_range(1, 4);
            pending   = 1'b1;
            pend_addr = imem_addr;
            cnt       = lat - 1;
            exp_req   = exp_req + 32'd4;
        end
        tgt      = ref_target(sel, p4, im, rg);
        hold_chk = if_valid && st && !rv;
        s_i      = if_instr;
        s_p      = if_pc;
        s_p4     = if_pc4;
        if (rv) begin
            exp_req = tgt;
            exp_pc  = tgt;
            nredir++;
        end else if (if_valid && !st) begin
            chk("slot_pc", if_pc, exp_pc);
            chk("slot_instr", if_instr, memfn(exp_pc));
            chk("slot_pc4", if_pc4, exp_pc + 32'd4);
            popq.push_back(if_pc);
            exp_pc = exp_pc + 32'd4;
            ncons++;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold_chk) begin
            chk("hold_valid", {31'b0, if_valid}, 32'd1);
            chk("hold_instr", if_instr, s_i);
            chk("hold_pc", if_pc, s_p);
            chk("hold_pc4", if_pc4, s_p4);
        end
        if (rv) chk("redir_clear", {31'b0, if_valid}, 32'd0);
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
    endtask

    task automatic do_reset(input int n, input logic stale);
        rst_n       = 1'b0;
        stall       = 1'b0;
        redir_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            imem_rvalid = stale && (i == 1);
            imem_rdata  = 32'hBAD0_0000;
            @(posedge clk);
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);
        pending = 1'b0;
        exp_req = RST_PC;
        exp_pc  = RST_PC;
        reqq.delete();
        popq.delete();
        rst_n = 1'b1;
    endtask

    task automatic post_reset_seq(input string tag);
        lat  = 1;
        spur = 1'b1;
        chk({tag, "_cyc1_noreq"}, {31'b0, imem_req}, 32'd0);
        idle_tick();
        spur = 1'b0;
        chk({tag, "_cyc2_req"}, {31'b0, imem_req}, 32'd1);
        for (int i = 0; i < 9; i++) idle_tick();
        chk({tag, "_req0"}, qat(reqq, 0), 32'h3000);
        chk({tag, "_req1"}, qat(reqq, 1), 32'h3004);
        chk({tag, "_req2"}, qat(reqq, 2), 32'h3008);
        chk({tag, "_pc0"}, qat(popq, 0), 32'h3000);
        chk({tag, "_pc1"}, qat(popq, 1), 32'h3004);
        chk({tag, "_pc2"}, qat(popq, 2), 32'h3008);
    endtask

    task automatic run_to_req();
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            idle_tick();
            n++;
        end
        chk("reach_fetch", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic redir_and_check(input string tag, input logic [1:0] sel,
                                   input logic [31:0] p4,
                                   input logic [25:0] im,
                                   input logic [31:0] rg,
                                   input logic [31:0] exp);
        tick(1'b0, 1'b1, sel, p4, im, rg);
        reqq.delete();
        popq.delete();
        for (int i = 0; i < 12 && popq.size() == 0; i++) idle_tick();
        chk({tag, "_req"}, qat(reqq, 0), exp);
        chk({tag, "_slot"}, qat(popq, 0), exp);
    endtask

    initial begin
        logic [31:0] slot_pc;
        int          base;
        checks      = 0;
        failures    = 0;
        pending     = 1'b0;
        pend_addr   = 32'h0;
        cnt         = 0;
        lat         = 1;
        rand_lat    = 1'b0;
        spur        = 1'b0;
        ncons       = 0;
        nredir      = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_sel   = 2'd0;
        redir_pc4   = 32'h0;
        redir_imm26 = 26'h0;
        redir_reg   = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        @(negedge clk);
        do_reset(4, 1'b1);
        post_reset_seq("boot");

        run_to_req();
        chk("hold_pre_valid", {31'b0, if_valid}, 32'd1);
        slot_pc = if_pc;
        reqq.delete();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        chk("stall_one_req", reqq.size(), 32'd1);
        chk("stall_slot_pc", if_pc, slot_pc);
        idle_tick();
        chk("release_valid", {31'b0, if_valid}, 32'd1);
        chk("release_pc", if_pc, slot_pc + 32'd4);
        chk("release_instr", if_instr, memfn(slot_pc + 32'd4));
        chk("release_req", {31'b0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, slot_pc + 32'd8);

        redir_and_check("br_back", 2'd0, 32'h3010, 26'h000FFFF, 32'd0, 32'h300C);
        redir_and_check("jump", 2'd1, 32'h3010, 26'h0000C40, 32'd0, 32'h3100);

        lat = 3;
        run_to_req();
        idle_tick();
        redir_and_check("jr_wait", 2'd2, 32'd0, 26'd0, 32'h3200, 32'h3200);

        lat = 1;
        run_to_req();
        idle_tick();
        redir_and_check("redir_rvalid", 2'd2, 32'd0, 26'd0, 32'h3400, 32'h3400);

        lat = 3;
        run_to_req();
        idle_tick();
        do_reset(3, 1'b1);
        post_reset_seq("rst_wait");

        rand_lat = 1'b1;
        base     = ncons;
        nredir   = 0;
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 6),
                 2'($urandom_range(0, 3)),
                 {16'h0, 14'($urandom), 2'b00},
                 26'($urandom),
                 {16'h0, 14'($urandom), 2'b00});
        end
        chk("rand_progress", {31'b0, (ncons - base) >= 50}, 32'd1);
        chk("rand_redirects", {31'b0, nredir >= 20}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
